dist_bcd_display: RTL and testbench
===================================

# dist_bcd_display

Downstream consumer of the echo pulse-width counter in the ultrasonic ranging path. It takes the 20-bit scaled distance word (units of 0.1 mm) and converts it to 7 BCD digits with a sequential double-dabble engine. It then time-multiplexes those digits onto an 8-digit active-low seven-segment display, with a decimal point marking the 0.1 mm digit. It runs on the same 1 MHz clock domain as the counter.

## Interface
- SCAN_DIV, 1000: clock cycles each digit stays lit (1 ms per digit at 1 MHz); legal range 2..65535.
- clk_1m  input  1  system clock, 1 MHz.
- rst  input  1  reset; asynchronous, active-low.
- dis_count  input  20  distance in 0.1 mm, unsigned, from the pulse-width counter.
- an  output  8  digit enables, active-low, one-hot; bit 0 is the rightmost digit.
- seg  output  8  segments, active-low, {dp,g,f,e,d,c,b,a}.
- bcd_out  output  28  latched BCD result, digit 6 in [27:24], digit 0 in [3:0].
- conv_busy  output  1  high while a conversion is in progress.

## Operation
- Reset values: an=8'hFF, seg=8'hFF, bcd_out=0, conv_busy=0, last_val=0, FSM=IDLE, scan counter=0, digit index=0.
- FSM states:
  - IDLE: if dis_count != last_val, latch dis_count into last_val and the shift register, clear the BCD accumulator, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: 20 iterations, one per clock. Each iteration adds 3 to every accumulator nibble that is >=5, then shifts {bcd,bin} left by 1. After the 20th iteration, go to DONE.
  - DONE: copy the accumulator to bcd_out and go to IDLE.
- Changes on dis_count during SHIFT or DONE are ignored. On return to IDLE the compare is repeated, so the display always converges to the latest input.
- Accumulator is 28 bits. The maximum input 1048575 fits in 7 digits, so no overflow path exists.
- Scan: the counter counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and the digit index increments, wrapping 7->0.
- Digit mapping:
  - Digits 0..6 show bcd_out nibbles 0..6 through a hex-to-7-seg decoder. Nibble values above 9 cannot occur; the decoder drives blank for them.
  - The dp segment is lit on digit 1 only, so the display reads mm with one decimal.
  - Digit 7 is always blank: its an bit is driven low and seg=8'hFF.
- an and seg are registered from the current digit index and the current bcd_out.

## Timing
- Call the clock edge at which IDLE detects a mismatch E0.
  - conv_busy rises after E0.
  - SHIFT iterations occur at E1..E20.
  - DONE updates bcd_out at E21; conv_busy falls after E21.
  - The earliest next compare is at E22.
- Conversion latency from input change to bcd_out is 21 cycles.
- an/seg lag the digit index by one cycle. Each digit is enabled for exactly SCAN_DIV cycles; a full frame is 8*SCAN_DIV cycles.
- A bcd_out update takes effect on the next registered an/seg value. No frame alignment is applied.
- Reset mid-conversion aborts the conversion and restores all reset values. After release, an input of 0 produces no conversion, because it equals last_val.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digits 6 down to 2 are blanked (seg=8'hFF) while they and every higher digit are zero.
  - Digits 1 and 0 are always shown, so 0 displays as "0.0".
- Undefined: all 7 digits are always shown; 0 displays as "00000.0".
- bcd_out is unaffected either way.

## Test plan
- Reset: assert rst low mid-scan -> an=8'hFF, seg=8'hFF, bcd_out=0, conv_busy=0 immediately, with no clock required.
- Conversion: dis_count 0->12345 -> conv_busy high for 21 cycles, then bcd_out=28'h0012345. Display reads "1234.5", with dp on digit 1 only.
- Maximum: dis_count=1048575 -> bcd_out=28'h1048575 after 21 cycles.
- Mid-conversion change: 500 -> 777 applied at E5 -> bcd_out=28'h0000500 at E21, a second conversion starts at E22, and bcd_out=28'h0000777 at E43.
- Scan (SCAN_DIV=4): an steps FE,FD,FB,F7,EF,DF,BF,7F, each for 4 cycles, and then repeats. While an=7F, seg=8'hFF.
- Blanking: dis_count=7.
  - With LEADING_ZERO_BLANK_EN, digits 6..2 show seg=FF and the display reads "0.7".
  - Without it, the display reads "00000.7".

Source files
------------

// File: rtl/dist_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : dist_bcd_display
// Purpose  : Converts the 20-bit ranging distance (0.1 mm units) to 7 BCD
//            digits with a sequential double-dabble engine, then scans those
//            digits onto an 8-digit active-low seven-segment display. The
//            decimal point marks the 0.1 mm digit.
// Ports    : clk_1m    - 1 MHz system clock
//            rst       - asynchronous active-low reset
//            dis_count - distance in 0.1 mm, unsigned
//            an        - digit enables, active-low one-hot, bit 0 rightmost
//            seg       - segments, active-low {dp,g,f,e,d,c,b,a}
//            bcd_out   - latched BCD result, digit 6 in [27:24]
//            conv_busy - high while a conversion is running
// Options  : LEADING_ZERO_BLANK_EN - blank leading zeros on digits 6..2
// Revision : 1.0 - initial release
// ============================================================================
module dist_bcd_display #(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk_1m,
    input  logic        rst,
    input  logic [19:0] dis_count,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic [27:0] bcd_out,
    output logic        conv_busy
);

    localparam logic [15:0] C_SCAN_LAST = 16'(SCAN_DIV - 1);
    localparam logic [4:0]  C_ITER_LAST = 5'd19;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic [19:0] last_val_q;
    logic [19:0] bin_q;
    logic [27:0] acc_q;
    logic [4:0]  iter_q;

    // Add 3 to every nibble that is 5 or more, so the following left shift
    // carries correctly into the next decimal digit.
    function automatic logic [27:0] dabble_adjust(input logic [27:0] b);
        logic [27:0] r;
        r = b;
        for (int i = 0; i < 7; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Active-high {g,f,e,d,c,b,a}; codes above 9 map to blank.
    function automatic logic [6:0] seg7_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [27:0] acc_adj;
    assign acc_adj = dabble_adjust(acc_q);

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_1m or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            last_val_q <= '0;
            bin_q      <= '0;
            acc_q      <= '0;
            iter_q     <= '0;
            bcd_out    <= '0;
            conv_busy  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dis_count != last_val_q) begin
                        last_val_q <= dis_count;
                        bin_q      <= dis_count;
                        acc_q      <= '0;
                        iter_q     <= '0;
                        conv_busy  <= 1'b1;
                        state_q    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // {acc,bin} shifted left by one after adjustment.
                    acc_q <= {acc_adj[26:0], bin_q[19]};
                    bin_q <= {bin_q[18:0], 1'b0};
                    if (iter_q == C_ITER_LAST) begin
                        state_q <= ST_DONE;
                    end else begin
                        iter_q <= iter_q + 5'd1;
                    end
                end
                ST_DONE: begin
                    bcd_out   <= acc_q;
                    conv_busy <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Digit scan
    // ------------------------------------------------------------------
    logic [15:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]  digit_q, digit_d;
    logic [7:0]  an_d, seg_d;
    logic [3:0]  nib [8];
    logic [7:0]  blank;

    always_comb begin
        scan_cnt_d = scan_cnt_q + 16'd1;
        digit_d    = digit_q;
        if (scan_cnt_q == C_SCAN_LAST) begin
            scan_cnt_d = '0;
            digit_d    = digit_q + 3'd1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_above;
`endif

    always_comb begin
        for (int k = 0; k < 7; k++) begin
            nib[k] = bcd_out[4*k +: 4];
        end
        nib[7] = 4'd0;
        // Digit 7 is permanently blank.
        blank = 8'b1000_0000;
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is blank when it and every digit above it are zero;
        // digits 1 and 0 always show so zero reads "0.0".
        zero_above = 1'b1;
        for (int k = 6; k >= 2; k--) begin
            zero_above = zero_above & (nib[k] == 4'd0);
            blank[k]   = zero_above;
        end
`endif
        an_d = ~(8'b1 << digit_q);
        if (blank[digit_q]) begin
            seg_d = 8'hFF;
        end else begin
            seg_d = {~(digit_q == 3'd1), ~seg7_decode(nib[digit_q])};
        end
    end

    always_ff @(posedge clk_1m or negedge rst) begin
        if (!rst) begin
            scan_cnt_q <= '0;
            digit_q    <= '0;
            an         <= 8'hFF;
            seg        <= 8'hFF;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            digit_q    <= digit_d;
            an         <= an_d;
            seg        <= seg_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dist_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_dist_bcd_display
// Purpose  : Self-checking bench for dist_bcd_display. Expected BCD and
//            segment values come from decimal arithmetic on the applied
//            distance, not from the design's shift-add structure.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dist_bcd_display;

    localparam int C_SCAN = 4;

    logic        clk_1m = 1'b0;
    logic        rst    = 1'b0;
    logic [19:0] dis_count = '0;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic [27:0] bcd_out;
    logic        conv_busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cur_val   = 0;

    dist_bcd_display #(.SCAN_DIV(C_SCAN)) dut (
        .clk_1m    (clk_1m),
        .rst       (rst),
        .dis_count (dis_count),
        .an        (an),
        .seg       (seg),
        .bcd_out   (bcd_out),
        .conv_busy (conv_busy)
    );

    always #5 clk_1m = ~clk_1m;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [27:0] exp_bcd(input int v);
        logic [27:0] r;
        r = '0;
        for (int k = 0; k < 7; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction

    function automatic logic [7:0] digit_pattern(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            default: return 8'h90;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input int v, input int k);
        logic [7:0] s;
        if (k == 7) return 8'hFF;
`ifdef LEADING_ZERO_BLANK_EN
        if (k >= 2 && v < pow10(k)) return 8'hFF;
`endif
        s = digit_pattern((v / pow10(k)) % 10);
        if (k == 1) s[7] = 1'b0;
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset;
        #12;
        total_cnt++;
        if (an !== 8'hFF) $display("FAIL reset_an: got %h expected ff", an);
        else pass_cnt++;
        total_cnt++;
        if (seg !== 8'hFF) $display("FAIL reset_seg: got %h expected ff", seg);
        else pass_cnt++;
        total_cnt++;
        if (bcd_out !== 28'h0) $display("FAIL reset_bcd: got %h expected 0", bcd_out);
        else pass_cnt++;
        total_cnt++;
        if (conv_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", conv_busy);
        else pass_cnt++;
    endtask

    task automatic test_scan;
        logic [7:0] exp_an;
        @(negedge clk_1m);
        rst = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int d = 0; d < 8; d++) begin
                exp_an = ~(8'b1 << d);
                for (int c = 0; c < C_SCAN; c++) begin
                    @(negedge clk_1m);
                    total_cnt++;
                    if (an !== exp_an)
                        $display("FAIL scan_an f%0d d%0d c%0d: got %h expected %h", f, d, c, an, exp_an);
                    else pass_cnt++;
                    if (d == 7) begin
                        total_cnt++;
                        if (seg !== 8'hFF) $display("FAIL scan_seg7: got %h expected ff", seg);
                        else pass_cnt++;
                    end
                end
            end
        end
    endtask

    task automatic check_display(input int v);
        logic [7:0] exp_an;
        int n;
        @(negedge clk_1m);
        for (int k = 0; k < 8; k++) begin
            exp_an = ~(8'b1 << k);
            n = 0;
            while (an !== exp_an && n < 8 * C_SCAN + 2) begin
                @(negedge clk_1m);
                n++;
            end
            total_cnt++;
            if (an !== exp_an) $display("FAIL disp_an v%0d k%0d: got %h expected %h", v, k, an, exp_an);
            else pass_cnt++;
            total_cnt++;
            if (seg !== exp_seg(v, k))
                $display("FAIL disp_seg v%0d k%0d: got %h expected %h", v, k, seg, exp_seg(v, k));
            else pass_cnt++;
        end
    endtask

    task automatic test_conversion(input int v);
        logic [27:0] old;
        old = exp_bcd(cur_val);
        @(negedge clk_1m);
        dis_count = 20'(v);
        for (int i = 0; i < 21; i++) begin
            @(negedge clk_1m);
            total_cnt++;
            if (conv_busy !== 1'b1 || bcd_out !== old)
                $display("FAIL conv_window v%0d i%0d: got busy=%b bcd=%h expected busy=1 bcd=%h",
                         v, i, conv_busy, bcd_out, old);
            else pass_cnt++;
        end
        @(negedge clk_1m);
        total_cnt++;
        if (conv_busy !== 1'b0 || bcd_out !== exp_bcd(v))
            $display("FAIL conv_result v%0d: got busy=%b bcd=%h expected busy=0 bcd=%h",
                     v, conv_busy, bcd_out, exp_bcd(v));
        else pass_cnt++;
        cur_val = v;
    endtask

    task automatic test_mid_change;
        logic [27:0] old;
        old = exp_bcd(cur_val);
        @(negedge clk_1m);
        dis_count = 20'd500;
        repeat (5) @(negedge clk_1m);
        dis_count = 20'd777;
        repeat (16) @(negedge clk_1m);
        total_cnt++;
        if (conv_busy !== 1'b1 || bcd_out !== old)
            $display("FAIL mid_e20: got busy=%b bcd=%h expected busy=1 bcd=%h", conv_busy, bcd_out, old);
        else pass_cnt++;
        @(negedge clk_1m);
        total_cnt++;
        if (conv_busy !== 1'b0 || bcd_out !== 28'h0000500)
            $display("FAIL mid_e21: got busy=%b bcd=%h expected busy=0 bcd=0000500", conv_busy, bcd_out);
        else pass_cnt++;
        @(negedge clk_1m);
        total_cnt++;
        if (conv_busy !== 1'b1)
            $display("FAIL mid_e22: got busy=%b expected 1", conv_busy);
        else pass_cnt++;
        repeat (20) @(negedge clk_1m);
        total_cnt++;
        if (bcd_out !== 28'h0000500)
            $display("FAIL mid_e42: got bcd=%h expected 0000500", bcd_out);
        else pass_cnt++;
        @(negedge clk_1m);
        total_cnt++;
        if (conv_busy !== 1'b0 || bcd_out !== 28'h0000777)
            $display("FAIL mid_e43: got busy=%b bcd=%h expected busy=0 bcd=0000777", conv_busy, bcd_out);
        else pass_cnt++;
        cur_val = 777;
    endtask

    task automatic test_random;
        int vals [4] = '{0, 9, 10, 99999};
        int v;
        int n;
        for (int it = 0; it < 12; it++) begin
            if (it < 4) v = vals[it];
            else v = int'($urandom_range(0, 1048575));
            if (v == cur_val) v = (v + 1) % 1048576;
            @(negedge clk_1m);
            dis_count = 20'(v);
            n = 0;
            while (!conv_busy && n < 5) begin
                @(negedge clk_1m);
                n++;
            end
            while (conv_busy && n < 40) begin
                @(negedge clk_1m);
                n++;
            end
            total_cnt++;
            if (conv_busy !== 1'b0 || bcd_out !== exp_bcd(v))
                $display("FAIL rand_bcd v%0d: got busy=%b bcd=%h expected busy=0 bcd=%h",
                         v, conv_busy, bcd_out, exp_bcd(v));
            else pass_cnt++;
            cur_val = v;
            if (it < 6) check_display(v);
        end
    endtask

    task automatic test_reset_mid;
        int v;
        v = (cur_val == 654321) ? 123456 : 654321;
        @(negedge clk_1m);
        dis_count = 20'(v);
        repeat (5) @(negedge clk_1m);
        #3 rst = 1'b0;
        #1;
        total_cnt++;
        if (an !== 8'hFF || seg !== 8'hFF)
            $display("FAIL rstmid_display: got an=%h seg=%h expected ff ff", an, seg);
        else pass_cnt++;
        total_cnt++;
        if (bcd_out !== 28'h0 || conv_busy !== 1'b0)
            $display("FAIL rstmid_conv: got bcd=%h busy=%b expected 0 0", bcd_out, conv_busy);
        else pass_cnt++;
        dis_count = '0;
        @(negedge clk_1m);
        rst = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk_1m);
            total_cnt++;
            if (conv_busy !== 1'b0 || bcd_out !== 28'h0)
                $display("FAIL rstmid_zero i%0d: got busy=%b bcd=%h expected 0 0", i, conv_busy, bcd_out);
            else pass_cnt++;
        end
        cur_val = 0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_conversion(12345);
        check_display(12345);
        test_conversion(1048575);
        check_display(1048575);
        test_mid_change();
        test_conversion(7);
        check_display(7);
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
